conv_tile_sched: RTL and testbench
==================================

# conv_tile_sched

Tile-loop scheduler that drives the start/done handshake of the convolution tile engine. It walks the full layer (R×C output rows/cols, N output channels, M input channels) in tile steps of Tr, Tc, Tn and Tm. For each tile it presents tile base coordinates, issues a one-cycle tile start, and waits for the tile's done pulse before advancing. It sits between the layer-level host control and the tile engine, and is the initiator side of the tile engine's start/done interface.

## Interface
Parameters:
- AW, 32, width of tile base outputs
- CW, 16, width of tile counter
- N, 32, output channels
- M, 32, input channels
- R, 64, feature rows
- C, 32, feature columns
- Tn, 16, output-channel tile step
- Tm, 16, input-channel tile step
- Tr, 64, row tile step
- Tc, 16, column tile step
- GAP, 2, idle cycles between a tile's done and the next tile start (≥0; covers the engine's one-cycle-delayed internal clean)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- layer_start  in  1  request to run a full layer; sampled only in IDLE
- layer_done  out  1  one-cycle pulse after the last tile completes
- busy  out  1  high from the cycle after accepted layer_start until layer_done inclusive
- conv_tile_start  out  1  one-cycle tile start pulse
- conv_tile_done  in  1  tile completion pulse from the tile engine
- tile_base_n  out  AW  current output-channel base
- tile_base_m  out  AW  current input-channel base
- tile_base_row  out  AW  current row base
- tile_base_col  out  AW  current column base
- tile_idx  out  CW  number of tiles completed in current layer

## Operation
- N, M, R and C must be integer multiples of Tn, Tm, Tr and Tc. Non-multiples are unsupported and are not checked in RTL.
- Total tiles T = (R/Tr)·(C/Tc)·(N/Tn)·(M/Tm). With defaults, T = 1·2·2·2 = 8.
- Loop order, innermost first: m, n, col, row.
  - m steps by Tm; at wrap (next value = M) m returns to 0 and n steps by Tn.
  - n wraps at N and carries into col (step Tc).
  - col wraps at C and carries into row (step Tr).
  - The last tile is reached when every base equals its max minus step.
- FSM states: IDLE, ISSUE, WAIT, GAP, FIN.
  - IDLE: bases = 0, tile_idx = 0. layer_start=1 → ISSUE.
  - ISSUE: exactly 1 cycle with conv_tile_start=1 → WAIT.
  - WAIT: conv_tile_done=1 → tile_idx+1.
    - If last tile → FIN.
    - Else advance bases at the same edge; then → GAP (GAP>0) or → ISSUE (GAP=0).
  - GAP: down-counter loaded with GAP-1; after GAP cycles → ISSUE.
  - FIN: 1 cycle, layer_done=1. Bases hold the last tile → IDLE, where bases and tile_idx clear.
- Outputs are registered. conv_tile_start and layer_done are Moore decodes of registered state.
- Bases are stable from ISSUE through the end of WAIT for every tile.
- conv_tile_done is ignored in IDLE, ISSUE, GAP and FIN.
- layer_start is ignored outside IDLE; no queuing.
- conv_tile_done and layer_start in the same cycle in IDLE: start accepted, done ignored.

## Timing
- Reset values: all outputs 0, state IDLE, GAP counter 0. Reset asserted mid-layer aborts immediately with no layer_done. The first layer_start after release starts a fresh layer at bases 0.
- layer_start sampled at edge k → busy and conv_tile_start high in cycle k+1, bases = 0.
- conv_tile_done high in cycle d (WAIT):
  - Next conv_tile_start is high in cycle d+1+GAP, with new bases already valid from cycle d+1.
  - If it was the last tile, layer_done is high in cycle d+1, busy drops in cycle d+2.
- Minimum tile period (engine done immediately after start) = GAP+2 cycles.
- tile_idx updates in cycle d+1. tile_idx = T during FIN and returns to 0 in IDLE.

## Test plan
- Default params, engine model returns done 10 cycles after each start → 8 starts. (m,n,col,row) sequence: (0,0,0,0), (16,0,0,0), (0,16,0,0), (16,16,0,0), (0,0,16,0), (16,0,16,0), (0,16,16,0), (16,16,16,0). layer_done once, tile_idx=8 at done, start spacing = 11+GAP cycles.
- GAP=0, done returned in the cycle after each start → starts every 2 cycles, 8 starts, layer_done 1 cycle after the 8th done.
- layer_start pulsed while busy, and spurious conv_tile_done during GAP and IDLE → no extra starts, no tile_idx change, sequence identical to scenario 1.
- rst low after the 3rd done (tile_idx=3) → all outputs 0 within the same cycle (async). Restart → first start has bases all 0, full 8-tile run.
- Tn=N, Tm=M, Tr=R, Tc=C → exactly one start at bases 0; layer_done 1 cycle after its done.
- layer_start held high continuously → a new layer begins 1 cycle after FIN→IDLE, with bases restarting at 0.

Source files
------------

// File: rtl/conv_tile_if.sv
// Tile-engine side of the scheduler: start/done handshake plus the current tile coordinates.
interface conv_tile_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
);
    logic          conv_tile_start;
    logic          conv_tile_done;
    logic [AW-1:0] tile_base_n;
    logic [AW-1:0] tile_base_m;
    logic [AW-1:0] tile_base_row;
    logic [AW-1:0] tile_base_col;
    logic [CW-1:0] tile_idx;

    modport master (
        output conv_tile_start, tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_idx,
        input  conv_tile_done
    );

    modport slave (
        input  conv_tile_start, tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_idx,
        output conv_tile_done
    );
endinterface

// File: rtl/conv_tile_sched.sv
// Walks a conv layer in (m, n, col, row) tile order, issuing one start per tile and
// waiting for the engine's done before advancing.
module conv_tile_sched #(
    parameter int unsigned AW  = 32,
    parameter int unsigned CW  = 16,
    parameter int unsigned N   = 32,
    parameter int unsigned M   = 32,
    parameter int unsigned R   = 64,
    parameter int unsigned C   = 32,
    parameter int unsigned Tn  = 16,
    parameter int unsigned Tm  = 16,
    parameter int unsigned Tr  = 64,
    parameter int unsigned Tc  = 16,
    parameter int unsigned GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_layer_start,
    output logic        o_layer_done,
    output logic        o_busy,
    conv_tile_if.master tile
);

    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [AW-1:0] r_base_m, r_base_n, r_base_col, r_base_row;
    logic [AW-1:0] w_base_m_nxt, w_base_n_nxt, w_base_col_nxt, w_base_row_nxt;
    logic [CW-1:0] r_tile_idx, w_tile_idx_nxt;
    logic          r_start, r_layer_done, r_busy;
    logic          w_last_m, w_last_n, w_last_col, w_last_row, w_last;
    logic          w_tile_done;

    assign w_last_m    = (r_base_m   == AW'(M - Tm));
    assign w_last_n    = (r_base_n   == AW'(N - Tn));
    assign w_last_col  = (r_base_col == AW'(C - Tc));
    assign w_last_row  = (r_base_row == AW'(R - Tr));
    assign w_last      = w_last_m && w_last_n && w_last_col && w_last_row;
    assign w_tile_done = (r_state == S_WAIT) && tile.conv_tile_done;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_layer_start) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (tile.conv_tile_done) begin
                    if (w_last)       w_state_nxt = S_FIN;
                    else if (GAP > 0) w_state_nxt = S_GAP;
                    else              w_state_nxt = S_ISSUE;
                end
            end
            S_GAP:   if (r_gap_cnt == '0) w_state_nxt = S_ISSUE;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter/base updates: bases advance on the done edge so they are valid before the next start
    always_comb begin
        w_gap_cnt_nxt  = r_gap_cnt;
        w_tile_idx_nxt = r_tile_idx;
        w_base_m_nxt   = r_base_m;
        w_base_n_nxt   = r_base_n;
        w_base_col_nxt = r_base_col;
        w_base_row_nxt = r_base_row;

        if (r_state == S_GAP && r_gap_cnt != '0) w_gap_cnt_nxt = r_gap_cnt - 1'b1;

        if (w_tile_done) begin
            w_tile_idx_nxt = r_tile_idx + 1'b1;
            w_gap_cnt_nxt  = GW'(GAP - 1);
            if (!w_last) begin
                w_base_m_nxt = w_last_m ? '0 : r_base_m + AW'(Tm);
                if (w_last_m) begin
                    w_base_n_nxt = w_last_n ? '0 : r_base_n + AW'(Tn);
                    if (w_last_n) begin
                        w_base_col_nxt = w_last_col ? '0 : r_base_col + AW'(Tc);
                        if (w_last_col) w_base_row_nxt = r_base_row + AW'(Tr);
                    end
                end
            end
        end

        if (w_state_nxt == S_IDLE) begin
            w_gap_cnt_nxt  = '0;
            w_tile_idx_nxt = '0;
            w_base_m_nxt   = '0;
            w_base_n_nxt   = '0;
            w_base_col_nxt = '0;
            w_base_row_nxt = '0;
        end
    end

    // Output registers; pulses decode the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap_cnt    <= '0;
            r_tile_idx   <= '0;
            r_base_m     <= '0;
            r_base_n     <= '0;
            r_base_col   <= '0;
            r_base_row   <= '0;
            r_start      <= 1'b0;
            r_layer_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_tile_idx   <= w_tile_idx_nxt;
            r_base_m     <= w_base_m_nxt;
            r_base_n     <= w_base_n_nxt;
            r_base_col   <= w_base_col_nxt;
            r_base_row   <= w_base_row_nxt;
            r_start      <= (w_state_nxt == S_ISSUE);
            r_layer_done <= (w_state_nxt == S_FIN);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign tile.conv_tile_start = r_start;
    assign tile.tile_base_m     = r_base_m;
    assign tile.tile_base_n     = r_base_n;
    assign tile.tile_base_col   = r_base_col;
    assign tile.tile_base_row   = r_base_row;
    assign tile.tile_idx        = r_tile_idx;
    assign o_layer_done         = r_layer_done;
    assign o_busy               = r_busy;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboard bench for conv_tile_sched: three instances (GAP=2, GAP=0, single tile) with engine models.
`timescale 1ns/1ps
module tb_conv_tile_sched;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    typedef struct { int m; int n; int col; int row; } tile_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    tile_t exp_q[$];

    logic ls0 = 1'b0, ls1 = 1'b0, ls2 = 1'b0;
    logic ld0, ld1, ld2, bz0, bz1, bz2;
    logic spur0 = 1'b0;
    int cnt0, cnt1, cnt2;
    int dly0 = 10, dly1 = 1, dly2 = 5;

    conv_tile_if #(.AW(AW), .CW(CW)) if0 ();
    conv_tile_if #(.AW(AW), .CW(CW)) if1 ();
    conv_tile_if #(.AW(AW), .CW(CW)) if2 ();

    conv_tile_sched #(.AW(AW), .CW(CW), .GAP(2)) u0 (
        .clk(clk), .rst(rst), .i_layer_start(ls0), .o_layer_done(ld0), .o_busy(bz0), .tile(if0));
    conv_tile_sched #(.AW(AW), .CW(CW), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .i_layer_start(ls1), .o_layer_done(ld1), .o_busy(bz1), .tile(if1));
    conv_tile_sched #(.AW(AW), .CW(CW), .Tn(32), .Tm(32), .Tr(64), .Tc(32), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .i_layer_start(ls2), .o_layer_done(ld2), .o_busy(bz2), .tile(if2));

    // Engine models: done is high dly cycles after the start cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0 <= 0; cnt1 <= 0; cnt2 <= 0;
        end else begin
            cnt0 <= if0.conv_tile_start ? dly0 : ((cnt0 > 0) ? cnt0 - 1 : 0);
            cnt1 <= if1.conv_tile_start ? dly1 : ((cnt1 > 0) ? cnt1 - 1 : 0);
            cnt2 <= if2.conv_tile_start ? dly2 : ((cnt2 > 0) ? cnt2 - 1 : 0);
        end
    end
    assign if0.conv_tile_done = (cnt0 == 1) || spur0;
    assign if1.conv_tile_done = (cnt1 == 1);
    assign if2.conv_tile_done = (cnt2 == 1);

    function automatic void push_layer(int nn, int mm, int rr, int cc, int tn, int tm, int tr, int tc);
        tile_t t;
        for (int r = 0; r < rr; r += tr)
            for (int c = 0; c < cc; c += tc)
                for (int n = 0; n < nn; n += tn)
                    for (int m = 0; m < mm; m += tm) begin
                        t.m = m; t.n = n; t.col = c; t.row = r;
                        exp_q.push_back(t);
                    end
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({if0.conv_tile_start, if0.tile_base_n, if0.tile_base_m, if0.tile_base_row,
             if0.tile_base_col, if0.tile_idx, ld0, bz0} !== '0) begin
            n_fail++; $display("FAIL reset_u0: outputs not zero, idx=%0d busy=%b", if0.tile_idx, bz0);
        end
        n_tests++;
        if ({if1.conv_tile_start, if1.tile_base_n, if1.tile_base_m, if1.tile_base_row,
             if1.tile_base_col, if1.tile_idx, ld1, bz1, if2.conv_tile_start, if2.tile_idx, ld2, bz2} !== '0) begin
            n_fail++; $display("FAIL reset_u1_u2: outputs not zero, busy1=%b busy2=%b", bz1, bz2);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (if0.conv_tile_start !== 1'b0 || bz0 !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: start=%b busy=%b expected 0 0", if0.conv_tile_start, bz0);
        end
    endtask

    // Full default layer on u0; noisy adds spurious done and layer_start pulses that must be ignored
    task automatic test_sequence(input bit noisy);
        tile_t e;
        int last_s, n_starts, cyc_ls;
        bit fin;
        last_s = -1; n_starts = 0; fin = 1'b0;
        exp_q.delete();
        push_layer(32, 32, 64, 32, 16, 16, 64, 16);
        @(negedge clk);
        if (noisy) begin
            spur0 = 1'b1;
            repeat (3) @(negedge clk);
            n_tests++;
            if (if0.conv_tile_start !== 1'b0 || if0.tile_idx !== '0 || bz0 !== 1'b0) begin
                n_fail++; $display("FAIL idle_spurious_done: start=%b idx=%0d busy=%b expected 0 0 0",
                                   if0.conv_tile_start, if0.tile_idx, bz0);
            end
        end
        ls0 = 1'b1; cyc_ls = cyc;
        @(negedge clk);
        ls0 = 1'b0; spur0 = 1'b0;
        n_tests++;
        if (if0.conv_tile_start !== 1'b1 || bz0 !== 1'b1) begin
            n_fail++; $display("FAIL start_latency: start=%b busy=%b expected 1 1", if0.conv_tile_start, bz0);
        end
        for (int k = 0; k < 400 && !fin; k++) begin
            if (if0.conv_tile_start) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL extra_start: start at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({if0.tile_base_m, if0.tile_base_n, if0.tile_base_col, if0.tile_base_row} !==
                        {32'(e.m), 32'(e.n), 32'(e.col), 32'(e.row)}) begin
                        n_fail++;
                        $display("FAIL tile_bases: got m=%0d n=%0d col=%0d row=%0d expected m=%0d n=%0d col=%0d row=%0d",
                                 if0.tile_base_m, if0.tile_base_n, if0.tile_base_col, if0.tile_base_row,
                                 e.m, e.n, e.col, e.row);
                    end
                end
                n_tests++;
                if (if0.tile_idx !== CW'(n_starts)) begin
                    n_fail++; $display("FAIL tile_idx_at_start: got %0d expected %0d", if0.tile_idx, n_starts);
                end
                n_tests++;
                if (last_s >= 0 && cyc - last_s !== 13) begin
                    n_fail++; $display("FAIL start_spacing: got %0d expected 13", cyc - last_s);
                end else if (last_s < 0 && cyc !== cyc_ls + 1) begin
                    n_fail++; $display("FAIL first_start_cycle: got %0d expected %0d", cyc, cyc_ls + 1);
                end
                last_s = cyc;
                n_starts++;
            end
            if (ld0) begin
                fin = 1'b1;
                n_tests++;
                if (if0.tile_idx !== CW'(8) || bz0 !== 1'b1 || n_starts != 8) begin
                    n_fail++; $display("FAIL layer_done: idx=%0d busy=%b starts=%0d expected 8 1 8",
                                       if0.tile_idx, bz0, n_starts);
                end
            end
            ls0   = noisy && bz0 && (k % 4 == 1);
            spur0 = noisy && bz0 && (cnt0 == 0);
            @(negedge clk);
        end
        ls0 = 1'b0; spur0 = 1'b0;
        n_tests++;
        if (!fin) begin
            n_fail++; $display("FAIL layer_timeout: no layer_done, starts=%0d expected 8", n_starts);
        end else if (bz0 !== 1'b0 || ld0 !== 1'b0 || if0.tile_idx !== '0 || if0.tile_base_n !== '0 ||
                     if0.tile_base_m !== '0 || if0.tile_base_col !== '0) begin
            n_fail++; $display("FAIL back_to_idle: busy=%b done=%b idx=%0d expected 0 0 0", bz0, ld0, if0.tile_idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gap0();
        tile_t e;
        int last_s, last_d, n_starts;
        bit fin;
        last_s = -1; last_d = -100; n_starts = 0; fin = 1'b0;
        exp_q.delete();
        push_layer(32, 32, 64, 32, 16, 16, 64, 16);
        ls1 = 1'b1;
        @(negedge clk);
        ls1 = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            if (if1.conv_tile_start) begin
                n_tests++;
                e = exp_q.pop_front();
                if ({if1.tile_base_m, if1.tile_base_n, if1.tile_base_col, if1.tile_base_row} !==
                    {32'(e.m), 32'(e.n), 32'(e.col), 32'(e.row)} ||
                    (last_s >= 0 && cyc - last_s !== 2)) begin
                    n_fail++; $display("FAIL gap0_start: m=%0d n=%0d col=%0d spacing=%0d expected m=%0d n=%0d col=%0d spacing 2",
                                       if1.tile_base_m, if1.tile_base_n, if1.tile_base_col, cyc - last_s, e.m, e.n, e.col);
                end
                last_s = cyc;
                n_starts++;
            end
            if (if1.conv_tile_done) last_d = cyc;
            if (ld1) begin
                fin = 1'b1;
                n_tests++;
                if (cyc !== last_d + 1 || n_starts != 8 || if1.tile_idx !== CW'(8)) begin
                    n_fail++; $display("FAIL gap0_done: at %0d last_done %0d starts=%0d idx=%0d expected +1 8 8",
                                       cyc, last_d, n_starts, if1.tile_idx);
                end
            end
            @(negedge clk);
        end
        if (!fin) begin
            n_tests++; n_fail++; $display("FAIL gap0_timeout: starts=%0d expected 8", n_starts);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen_done, hit;
        seen_done = 1'b0; hit = 1'b0;
        ls0 = 1'b1;
        @(negedge clk);
        ls0 = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (ld0) seen_done = 1'b1;
            if (if0.tile_idx === CW'(3)) hit = 1'b1;
            else @(negedge clk);
        end
        n_tests++;
        if (!hit || seen_done) begin
            n_fail++; $display("FAIL reset_mid_reach: hit=%b early_done=%b expected 1 0", hit, seen_done);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({if0.conv_tile_start, if0.tile_base_n, if0.tile_base_m, if0.tile_base_row,
             if0.tile_base_col, if0.tile_idx, ld0, bz0} !== '0) begin
            n_fail++; $display("FAIL async_reset: idx=%0d busy=%b n=%0d expected all 0", if0.tile_idx, bz0, if0.tile_base_n);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (ld0 !== 1'b0 || bz0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: done=%b busy=%b expected 0 0", ld0, bz0);
        end
    endtask

    task automatic test_single_tile();
        int n_starts, last_d;
        bit fin;
        n_starts = 0; last_d = -100; fin = 1'b0;
        ls2 = 1'b1;
        @(negedge clk);
        ls2 = 1'b0;
        for (int k = 0; k < 50 && !fin; k++) begin
            if (if2.conv_tile_start) begin
                n_starts++;
                n_tests++;
                if ({if2.tile_base_m, if2.tile_base_n, if2.tile_base_col, if2.tile_base_row} !== '0) begin
                    n_fail++; $display("FAIL single_bases: m=%0d n=%0d col=%0d row=%0d expected 0",
                                       if2.tile_base_m, if2.tile_base_n, if2.tile_base_col, if2.tile_base_row);
                end
            end
            if (if2.conv_tile_done) last_d = cyc;
            if (ld2) begin
                fin = 1'b1;
                n_tests++;
                if (cyc !== last_d + 1 || n_starts != 1 || if2.tile_idx !== CW'(1)) begin
                    n_fail++; $display("FAIL single_done: at %0d last_done %0d starts=%0d idx=%0d expected +1 1 1",
                                       cyc, last_d, n_starts, if2.tile_idx);
                end
            end
            @(negedge clk);
        end
        if (!fin) begin
            n_tests++; n_fail++; $display("FAIL single_timeout: starts=%0d expected 1", n_starts);
        end
    endtask

    // layer_start held high: the next layer starts the cycle after the single IDLE cycle
    task automatic test_back_to_back();
        int n2;
        bit fin;
        fin = 1'b0; n2 = 1;
        ls1 = 1'b1;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (ld1) fin = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (!fin || bz1 !== 1'b0 || if1.conv_tile_start !== 1'b0 || if1.tile_idx !== '0) begin
            n_fail++; $display("FAIL b2b_idle: fin=%b busy=%b start=%b idx=%0d expected 1 0 0 0",
                               fin, bz1, if1.conv_tile_start, if1.tile_idx);
        end
        @(negedge clk);
        n_tests++;
        if (if1.conv_tile_start !== 1'b1 || bz1 !== 1'b1 ||
            {if1.tile_base_m, if1.tile_base_n, if1.tile_base_col, if1.tile_base_row} !== '0) begin
            n_fail++; $display("FAIL b2b_restart: start=%b busy=%b m=%0d n=%0d expected 1 1 0 0",
                               if1.conv_tile_start, bz1, if1.tile_base_m, if1.tile_base_n);
        end
        ls1 = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (if1.conv_tile_start) n2++;
            if (ld1) fin = 1'b1;
        end
        n_tests++;
        if (!fin || n2 != 8) begin
            n_fail++; $display("FAIL b2b_second_layer: done=%b starts=%0d expected 1 8", fin, n2);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sequence(1'b0);
        test_gap0();
        test_sequence(1'b1);
        test_reset_mid();
        test_sequence(1'b0);
        test_single_tile();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
